// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: entry FSM states, opcode
// encodings shared with the calculator, and LED stage codes.
package calc_pkg;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    ISSUE  = 3'd3,
    DONE   = 3'd4
  } entry_state_t;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;

  localparam logic [1:0] STAGE_A     = 2'd0;
  localparam logic [1:0] STAGE_B     = 2'd1;
  localparam logic [1:0] STAGE_OP    = 2'd2;
  localparam logic [1:0] STAGE_ISSUE = 2'd3;

  // The switch bank is 4 bits wide; the top bit must be clear for a legal opcode.
  function automatic logic is_valid_op(input logic [3:0] code);
    return !code[3] && (code[2:0] >= OP_ADD) && (code[2:0] <= OP_OR);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces one raw active-low button and emits a one-cycle
// press pulse on each debounced release-to-press transition.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic ac,
  input  logic raw_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // NOTE: all state here uses non-blocking assignments so the two synchronizer
  // flops shift correctly; a blocking write would collapse them into one.
  always_ff @(posedge clk) begin
    if (!ac) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= '0;
          // Only the released->pressed flip (stable was 1) is a press.
          press  <= stable;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/calc_entry_fsm.sv
// Operator entry front end: debounced ENTER/BACK buttons step through operand A,
// operand B and opcode capture, then issue one active-low equals strobe.
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int EQ_DELAY        = 2
) (
  input  logic       clk,
  input  logic       ac,
  input  logic [3:0] sw,
  input  logic       key_n,
  input  logic       back_n,
  output logic [3:0] opt_a,
  output logic [3:0] opt_b,
  output logic [2:0] do_opt,
  output logic       equal_to,
  output logic [1:0] stage,
  output logic       err
);

  localparam int EW = (EQ_DELAY > 0) ? $clog2(EQ_DELAY + 1) : 1;

  logic         key_press;
  logic         back_press;
  entry_state_t state;
  logic [EW-1:0] eq_cnt;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .clk   (clk),
    .ac    (ac),
    .raw_n (key_n),
    .press (key_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back_db (
    .clk   (clk),
    .ac    (ac),
    .raw_n (back_n),
    .press (back_press)
  );

  always_ff @(posedge clk) begin
    if (!ac) begin
      state    <= GET_A;
      opt_a    <= '0;
      opt_b    <= '0;
      do_opt   <= '0;
      equal_to <= 1'b1;
      stage    <= STAGE_A;
      err      <= 1'b0;
      eq_cnt   <= '0;
    end else begin
      equal_to <= 1'b1;
      if (state == ISSUE) begin
        // Buttons are ignored here; the strobe fires in the cycle the counter reads zero.
        if (eq_cnt == '0) begin
          equal_to <= 1'b0;
          state    <= DONE;
        end else begin
          eq_cnt <= eq_cnt - 1'b1;
        end
      end else if (back_press) begin
        // BACK wins over a simultaneous ENTER; captured operands are left alone.
        case (state)
          GET_B: begin
            state <= GET_A;
            stage <= STAGE_A;
            err   <= 1'b0;
          end
          GET_OP: begin
            state <= GET_B;
            stage <= STAGE_B;
            err   <= 1'b0;
          end
          DONE: begin
            state <= GET_OP;
            stage <= STAGE_OP;
            err   <= 1'b0;
          end
          default: ;
        endcase
      end else if (key_press) begin
        case (state)
          GET_A: begin
            opt_a <= sw;
            state <= GET_B;
            stage <= STAGE_B;
          end
          GET_B: begin
            opt_b <= sw;
            state <= GET_OP;
            stage <= STAGE_OP;
          end
          GET_OP: begin
            if (is_valid_op(sw)) begin
              do_opt <= sw[2:0];
              err    <= 1'b0;
              eq_cnt <= EW'(EQ_DELAY);
              state  <= ISSUE;
              stage  <= STAGE_ISSUE;
            end else begin
              err <= 1'b1;
            end
          end
          DONE: begin
            state <= GET_A;
            stage <= STAGE_A;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
